// File: rtl/thirty_two_bit_divider.sv
// Multi-cycle restoring integer divider (signed/unsigned), one quotient bit per clock.
// Start/busy/done handshake; results and div_by_zero are held until the next result lands.
module thirty_two_bit_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  // Partial remainder; the extra top bit only exists in the shifted/trial values.
  logic [WIDTH-1:0]  rem_q, rem_d;
  // Dividend magnitude, shifted out MSB-first while quotient bits shift in at the LSB.
  logic [WIDTH-1:0]  dvd_q, dvd_d;
  logic [WIDTH-1:0]  dsr_q, dsr_d;
  logic              neg_quo_q, neg_quo_d;
  logic              neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]  quotient_q, quotient_d;
  logic [WIDTH-1:0]  remainder_q, remainder_d;
  logic              dbz_q, dbz_d;

  logic [WIDTH:0]    shifted;
  logic [WIDTH:0]    trial;
  logic              accept;

  // Next-state and datapath for all four states.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    dvd_d       = dvd_q;
    dsr_d       = dsr_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    shifted = {rem_q, dvd_q[WIDTH-1]};
    trial   = shifted - {1'b0, dsr_q};
    accept  = start && ((state_q == StIdle) || (state_q == StDone));

    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (accept) begin
          if (divisor == '0) begin
            // Divide by zero skips the iteration entirely.
            quotient_d  = '1;
            remainder_d = dividend;
            dbz_d       = 1'b1;
            state_d     = StDone;
          end else begin
            dvd_d     = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
            dsr_d     = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
            neg_quo_d = is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_rem_d = is_signed && dividend[WIDTH-1];
            rem_d     = '0;
            cnt_d     = '0;
            state_d   = StCalc;
          end
        end
      end
      StCalc: begin
        // Non-negative trial result means the divisor fits: keep it, quotient bit 1.
        if (!trial[WIDTH]) begin
          rem_d = trial[WIDTH-1:0];
          dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted[WIDTH-1:0];
          dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d = StFix;
        end
      end
      StFix: begin
        // Truncating division: remainder takes the dividend's sign.
        quotient_d  = neg_quo_q ? -dvd_q : dvd_q;
        remainder_d = neg_rem_q ? -rem_q : rem_q;
        dbz_d       = 1'b0;
        state_d     = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and result registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      rem_q       <= '0;
      dvd_q       <= '0;
      dsr_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      dvd_q       <= dvd_d;
      dsr_q       <= dsr_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign busy        = (state_q == StCalc) || (state_q == StFix);
  assign done        = (state_q == StDone);
  assign div_by_zero = dbz_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;

endmodule

// File: tb/tb_thirty_two_bit_divider.sv
// Self-checking bench for thirty_two_bit_divider: directed cases plus random operands
// compared against a plain-arithmetic reference model.
module tb_thirty_two_bit_divider;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] quotient;
  logic [31:0] remainder;

  int checks = 0;
  int errors = 0;

  thirty_two_bit_divider #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .quotient    (quotient),
    .remainder   (remainder)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Reference: language division, truncating toward zero.
  function automatic void model(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r, output logic z);
    z = 1'b0;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
      z = 1'b1;
    end else if (!sgn) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      q = 32'($signed(a) / $signed(b));
      r = 32'($signed(a) % $signed(b));
    end
  endfunction

  // Issue one operation from just after an edge; returns just after the edge where done rises.
  // glitch >= 0 pulses start with other operands that many cycles into the run.
  task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input string tag, input int glitch);
    logic [31:0] eq, er, pq, pr;
    logic        ez, pz;
    int          n;
    model(sgn, a, b, eq, er, ez);
    pq = quotient;
    pr = remainder;
    pz = div_by_zero;
    start = 1'b1; is_signed = sgn; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0; is_signed = 1'($urandom); dividend = $urandom; divisor = $urandom;
    if (b != 32'd0) begin
      chk({tag, "_hold_q"}, quotient, pq);
      chk({tag, "_hold_r"}, remainder, pr);
      chk1({tag, "_hold_dbz"}, div_by_zero, pz);
    end
    n = 0;
    while (!done && n < 40) begin
      chk1({tag, "_busy"}, busy, 1'b1);
      if (n == glitch) begin
        start = 1'b1; dividend = 32'd77; divisor = 32'd3;
      end
      @(posedge clk); #1;
      start = 1'b0;
      n++;
    end
    chk({tag, "_latency"}, 32'(n), (b == 32'd0) ? 32'd0 : 32'd33);
    chk1({tag, "_busy_at_done"}, busy, 1'b0);
    chk({tag, "_q"}, quotient, eq);
    chk({tag, "_r"}, remainder, er);
    chk1({tag, "_dbz"}, div_by_zero, ez);
  endtask

  initial begin
    logic [31:0] a, b, hq, hr;
    int          sel, seen;
    rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    #1;
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_dbz", div_by_zero, 1'b0);
    chk("rst_q", quotient, 32'd0);
    chk("rst_r", remainder, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Unsigned basic, single done pulse, hold.
    run_op(1'b0, 32'd100, 32'd7, "u100_7", -1);
    chk("u100_7_q_const", quotient, 32'd14);
    chk("u100_7_r_const", remainder, 32'd2);
    hq = quotient; hr = remainder;
    @(posedge clk); #1;
    chk1("done_single_pulse", done, 1'b0);
    repeat (4) begin @(posedge clk); #1; end
    chk("hold5_q", quotient, hq);
    chk("hold5_r", remainder, hr);
    chk1("hold5_done", done, 1'b0);

    // Sign rules.
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, "s_m7_2", -1);
    chk("s_m7_2_q_const", quotient, 32'hFFFF_FFFD);
    chk("s_m7_2_r_const", remainder, 32'hFFFF_FFFF);
    run_op(1'b1, 32'd7, 32'hFFFF_FFFE, "s_7_m2", -1);
    run_op(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, "s_m7_m2", -1);
    run_op(1'b0, 32'hFFFF_FFF9, 32'd2, "u_fff9_2", -1);
    chk("u_fff9_2_q_const", quotient, 32'h7FFF_FFFC);

    // Divide by zero, then a normal op clears the flag.
    run_op(1'b1, 32'h1234_5678, 32'd0, "dbz", -1);
    chk1("dbz_flag_const", div_by_zero, 1'b1);
    @(posedge clk); #1;
    run_op(1'b1, 32'd50, 32'hFFFF_FFFB, "after_dbz", -1);

    // Overflow and extremes.
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "ovf", -1);
    chk("ovf_q_const", quotient, 32'h8000_0000);
    run_op(1'b0, 32'hFFFF_FFFF, 32'd1, "u_max_1", -1);
    run_op(1'b0, 32'd5, 32'd9, "u5_9", -1);

    // Start ignored mid-run, then back-to-back from the done cycle.
    @(posedge clk); #1;
    run_op(1'b0, 32'd1000, 32'd10, "ignore_start", 10);
    chk("ignore_start_q_const", quotient, 32'd100);
    run_op(1'b0, 32'd9, 32'd4, "b2b", -1);
    chk("b2b_q_const", quotient, 32'd2);
    chk("b2b_r_const", remainder, 32'd1);

    // Asynchronous reset in the middle of CALC.
    @(posedge clk); #1;
    start = 1'b1; is_signed = 1'b0; dividend = 32'd123456; divisor = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    chk1("midrst_busy", busy, 1'b0);
    chk1("midrst_done", done, 1'b0);
    chk1("midrst_dbz", div_by_zero, 1'b0);
    chk("midrst_q", quotient, 32'd0);
    chk("midrst_r", remainder, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    chk("midrst_no_done", 32'(seen), 32'd0);
    run_op(1'b0, 32'd50, 32'd5, "u50_5", -1);

    // Random operands.
    for (int i = 0; i < 24; i++) begin
      a   = $urandom;
      sel = int'($urandom_range(3, 0));
      case (sel)
        0: b = $urandom;
        1: b = 32'($urandom_range(15, 0));
        2: b = -32'($urandom_range(9, 1));
        default: begin a = a >> $urandom_range(31, 0); b = $urandom >> $urandom_range(31, 0); end
      endcase
      run_op(1'($urandom), a, b, $sformatf("rand%0d", i), -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/thirty_two_bit_divider.md
Name: thirty_two_bit_divider

Overview:
Multi-cycle 32-bit integer divider, the inverse arithmetic path to the datapath's ripple adder. It uses restoring division and produces one quotient bit per clock. It is the multi-cycle DIV/DIVU unit beside the ALU and supports signed and unsigned operation. A start/busy/done handshake lets the control FSM stall while the division runs.

Parameters:
WIDTH, 32, operand/result width in bits; all arithmetic rules below scale with WIDTH.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request a division; sampled on rising edge of clk
is_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start
dividend  input  WIDTH  numerator; sampled with start
divisor  input  WIDTH  denominator; sampled with start
busy  output  1  high while a division is in progress (states CALC, FIX)
done  output  1  one-cycle pulse; quotient/remainder valid from this cycle on
div_by_zero  output  1  high alongside done when the captured divisor was 0; held with results
quotient  output  WIDTH  result quotient; held until the next accepted start
remainder  output  WIDTH  result remainder; held until the next accepted start

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low on rst_n.
- Reset (rst_n=0, any state, including mid-division): state=IDLE, busy=0, done=0, div_by_zero=0, quotient=0, remainder=0, iteration counter=0. The in-flight operation is discarded and no done is produced for it.
- States: IDLE, CALC, FIX, DONE.
- Accepting start:
  - start=1 is accepted only in IDLE or DONE, which allows back-to-back operations.
  - start is ignored in CALC and FIX; operands are not re-sampled.
- Accepting edge, divisor != 0:
  - Capture magnitudes |dividend| and |divisor|. Magnitude is taken only when is_signed=1 and the MSB=1.
  - Capture sign_q = dividend MSB XOR divisor MSB, and sign_r = dividend MSB. Both are forced to 0 when is_signed=0.
  - Clear the partial remainder (WIDTH+1 bits) and the counter; state -> CALC.
- CALC, one edge per quotient bit, WIDTH edges total:
  - Shift {partial remainder, dividend register} left by 1.
  - Trial-subtract the divisor magnitude from the partial remainder.
  - If the result is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0.
  - Counter increments each edge; after the edge with counter = WIDTH-1, state -> FIX.
- FIX (one edge):
  - quotient = sign_q ? -Q : Q; remainder = sign_r ? -R : R.
  - The remainder sign follows the dividend (truncating division).
  - div_by_zero=0; state -> DONE.
- DONE (one cycle): done=1, busy=0. Next edge -> IDLE, or -> a new operation if start=1.
- Latency: done is high in the cycle after the (WIDTH+1)th rising edge following the accepting edge, i.e. 33 edges for WIDTH=32.
- Divide by zero:
  - On the accepting edge, go directly to DONE with quotient = all ones, remainder = dividend (raw, unmodified) and div_by_zero=1.
  - done is therefore high in the cycle right after the accepting edge, for signed and unsigned alike.
- Signed overflow (is_signed=1, dividend = 0x80000000, divisor = 0xFFFFFFFF):
  - This falls out of the normal algorithm: quotient = 0x80000000, remainder = 0. No flag is raised.
- Magnitude of the most negative value: -0x80000000 is treated as the unsigned value 0x80000000 (WIDTH-bit wrap). No special case is needed.
- Output holding: quotient, remainder and div_by_zero change only on the FIX edge, the divide-by-zero accepting edge, or reset. They stay stable through IDLE and through the CALC of the following operation.
- busy and done are never both 1.

Test Plan:
- Reset, unsigned basic, hold:
  - Reset, then start with is_signed=0, dividend=100, divisor=7 -> busy high 33 cycles, done pulses once, quotient=14, remainder=2.
  - Results remain unchanged 5 cycles later with start low.
- Signed sign rules, four separate runs:
  - -7/2 -> q=0xFFFFFFFD (-3), r=0xFFFFFFFF (-1).
  - 7/-2 -> q=-3, r=1.
  - -7/-2 -> q=3, r=-1.
  - is_signed=0 with 0xFFFFFFF9/2 -> q=0x7FFFFFFC, r=1.
- Divide by zero:
  - dividend=0x12345678, divisor=0, is_signed=1 -> done in the cycle after the accepting edge, q=0xFFFFFFFF, r=0x12345678, div_by_zero=1.
  - The next normal op clears div_by_zero at its done.
- Overflow and extremes:
  - Signed 0x80000000/0xFFFFFFFF -> q=0x80000000, r=0.
  - Unsigned 0xFFFFFFFF/1 -> q=0xFFFFFFFF, r=0.
  - Unsigned 5/9 -> q=0, r=5.
- Handshake and back-to-back:
  - Pulse start again at CALC cycle 10 with different operands -> ignored; first result 1000/10 -> q=100, r=0.
  - Assert start during the done cycle with 9/4 -> accepted; second done 33 edges later with q=2, r=1.
- Reset mid-operation:
  - Drop rst_n at CALC cycle 15 -> all outputs 0 immediately, asynchronously; no done follows.
  - After release, a new 50/5 yields q=10, r=0.
